conv_controller: RTL and testbench
==================================

Name: conv_controller

Overview:
- Sequencer for the single-kernel convolution datapath (weight register, line-buffer shift registers, multiplier, adder tree).
- On `start`, it pulses the weight-register write, then streams one IMAGE_SIZE x IMAGE_SIZE frame from pixel memory in row-major order.
- It flags the cycles in which the datapath's combinational result holds a complete, non-wrapping KERNEL_SIZE x KERNEL_SIZE window, and tags each with its output index.
- The datapath has no shift enable, so the controller never stalls mid-frame.

Parameters:
- KERNEL_SIZE, 5, window edge length.
- IMAGE_SIZE, 28, input frame edge length.
- RD_LATENCY, 1, cycles from `pixel_addr`/`pixel_rd_en` to data on the datapath `pixel_input` (range 1..4).
- ADDR_W, $clog2(IMAGE_SIZE**2), pixel address width (10).
- OUT_W, $clog2((IMAGE_SIZE-KERNEL_SIZE+1)**2), output index width (10).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle request to process a frame; sampled only in IDLE.
- weight_write  out  1  drives the datapath `write`; one-cycle pulse.
- pixel_rd_en  out  1  pixel memory read strobe.
- pixel_addr  out  ADDR_W  row-major pixel index, 0..IMAGE_SIZE**2-1.
- out_valid  out  1  datapath `add_result` is a valid window this cycle.
- out_addr  out  OUT_W  row-major output index for the current out_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and every counter and the valid delay line are cleared. Reset asserted mid-frame aborts at once. The datapath shift registers are reset by the same signal.
- FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
  - IDLE -> LOAD when start=1.
  - LOAD: one cycle with weight_write=1; -> STREAM.
  - STREAM: exactly IMAGE_SIZE**2 cycles with pixel_rd_en=1; pixel_addr counts 0,1,...,IMAGE_SIZE**2-1; -> DRAIN after the last address.
  - DRAIN: RD_LATENCY+1 cycles with pixel_rd_en=0; -> DONE.
  - DONE: done=1 for one cycle; -> IDLE.
- start while busy is ignored and not queued. start in the same cycle that DONE is entered is also ignored.
- The stream does not pause: pixel_rd_en stays continuously high in STREAM.
- Column/row counters (c,r) track each issued address:
  - c wraps at IMAGE_SIZE-1 to 0 and increments r.
  - The window tag is 1 iff r >= KERNEL_SIZE-1 and c >= KERNEL_SIZE-1. Columns c < KERNEL_SIZE-1 would straddle a row boundary and are never valid.
- The tag travels through an (RD_LATENCY+1)-deep delay line:
  - pixel i reaches `pixel_input` RD_LATENCY cycles after its address;
  - the shift registers capture it at the end of that cycle;
  - `add_result` reflects the window ending at i one cycle later.
  - Therefore out_valid for pixel i is asserted exactly RD_LATENCY+1 cycles after the cycle pixel_addr=i.
- out_addr starts at 0 per frame, increments after each out_valid, and holds between pulses. Frame total is (IMAGE_SIZE-KERNEL_SIZE+1)**2 = 576 pulses.
- The last out_valid occurs in the final DRAIN cycle, one cycle before done.
- pixel_addr holds its last value outside STREAM; it is don't-care while pixel_rd_en=0.
- Counter and index arithmetic is unsigned with no saturation; widths are sized by the parameters.

Optional Feature:
- Macro: CONV_PERF_CNT_EN.
- When defined: adds output `perf_cycles` (32 bits), cleared by reset and at LOAD entry, incremented every cycle busy=1 (saturating at all-ones), and holding its value in IDLE. For defaults the held value after a frame is 788.
- When undefined: the port and the counter are absent.

Decomposition:
- Shared package `conv_pkg`:
  - state enum (IDLE/LOAD/STREAM/DRAIN/DONE);
  - localparams for frame size, output count and output edge (IMAGE_SIZE-KERNEL_SIZE+1);
  - ADDR_W/OUT_W helper functions.
- One natural sub-module, `valid_delay_line`: parameterised-depth shift of {tag} with asynchronous reset.
- The FSM and the counters stay in `conv_controller`.

Test Plan:
- Defaults, RD_LATENCY=1, start pulse in cycle 0 -> weight_write=1 only in cycle 1; pixel_addr 0..783 in cycles 2..785; done in cycle 788 only; busy high in cycles 1..788.
- Same run, out_valid checks -> first out_valid in cycle 120 with out_addr=0 (pixel 116, r=4, c=4); out_valid low in cycles for c=0..3 of each row; exactly 576 pulses; last in cycle 787 with out_addr=575.
- Golden compare -> model a 1-cycle memory driving a real datapath with known weights and bias; every add_result sampled on out_valid matches a software 5x5 convolution at out_addr.
- Reset asserted asynchronously mid-STREAM (pixel_addr=300) -> all outputs 0 immediately, state IDLE; a new start then runs a clean full frame with out_addr restarting at 0.
- start pulsed during STREAM and again in the DONE cycle -> both ignored, no second LOAD; a start in the following IDLE cycle is accepted.
- RD_LATENCY=3, CONV_PERF_CNT_EN defined -> first out_valid in cycle 122, done in cycle 790, perf_cycles holds 790 afterwards.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and sizing helpers for the convolution sequencer.
//   state_e        controller FSM states
//   frame_size()   pixels per input frame
//   out_edge()     edge length of the valid output map
//   out_count()    outputs per frame
//   addr_w()       pixel address width
//   out_w()        output index width
//   coord_w()      width of a row/column counter
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    function automatic int frame_size(input int img);
        return img * img;
    endfunction

    function automatic int out_edge(input int img, input int k);
        return img - k + 1;
    endfunction

    function automatic int out_count(input int img, input int k);
        return out_edge(img, k) * out_edge(img, k);
    endfunction

    function automatic int addr_w(input int img);
        return $clog2(frame_size(img));
    endfunction

    function automatic int out_w(input int img, input int k);
        return $clog2(out_count(img, k));
    endfunction

    function automatic int coord_w(input int img);
        return (img > 1) ? $clog2(img) : 1;
    endfunction

    localparam int DEF_KERNEL_SIZE = 5;
    localparam int DEF_IMAGE_SIZE  = 28;
    localparam int DEF_FRAME_SIZE  = frame_size(DEF_IMAGE_SIZE);
    localparam int DEF_OUT_EDGE    = out_edge(DEF_IMAGE_SIZE, DEF_KERNEL_SIZE);
    localparam int DEF_OUT_COUNT   = out_count(DEF_IMAGE_SIZE, DEF_KERNEL_SIZE);

endpackage

// File: rtl/conv_controller_valid_delay_line.sv
// valid_delay_line: fixed-depth shift register for the window tag.
//   clk    clock
//   rst    asynchronous active-high reset, clears every stage
//   tag_i  tag for the address issued this cycle
//   tag_o  tag delayed by DEPTH cycles
// DEPTH must be at least 2 (memory latency of at least one cycle plus the
// datapath capture cycle).
module valid_delay_line
    import conv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tag_i,
    output logic tag_o
);

    logic [DEPTH-1:0] pipe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= {pipe_q[DEPTH-2:0], tag_i};
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv_controller.sv
// conv_controller: sequencer for the single-kernel convolution datapath.
// Pulses the weight write, streams one frame of pixel addresses in row-major
// order without pausing, and flags the cycles in which the datapath adder
// holds a complete, non-wrapping window, tagged with its output index.
//   clk           clock, rising edge
//   reset         asynchronous active-high reset
//   start         frame request, sampled only in IDLE
//   weight_write  one-cycle datapath weight-register write
//   pixel_rd_en   pixel memory read strobe
//   pixel_addr    row-major pixel index
//   out_valid     datapath add_result is a valid window
//   out_addr      row-major output index for out_valid
//   busy          high outside IDLE
//   done          one-cycle end-of-frame pulse
//   perf_cycles   busy-cycle counter (only with CONV_PERF_CNT_EN)
// Optional macro: CONV_PERF_CNT_EN adds the saturating perf_cycles output.
module conv_controller
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE,
    parameter int RD_LATENCY  = 1,
    parameter int ADDR_W      = addr_w(IMAGE_SIZE),
    parameter int OUT_W       = out_w(IMAGE_SIZE, KERNEL_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              weight_write,
    output logic              pixel_rd_en,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_addr,
    output logic              busy,
`ifdef CONV_PERF_CNT_EN
    output logic [31:0]       perf_cycles,
`endif
    output logic              done
);

    localparam int CW = coord_w(IMAGE_SIZE);
    localparam int DW = $clog2(RD_LATENCY + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(frame_size(IMAGE_SIZE) - 1);
    localparam logic [CW-1:0]     LAST_COL   = CW'(IMAGE_SIZE - 1);
    localparam logic [CW-1:0]     WIN_START  = CW'(KERNEL_SIZE - 1);
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(RD_LATENCY);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     col_q, col_d;
    logic [CW-1:0]     row_q, row_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [OUT_W-1:0]  oidx_q, oidx_d;
    logic              tag;
    logic              valid;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        drain_d = drain_q;
        oidx_d  = oidx_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_STREAM;
                addr_d  = '0;
                col_d   = '0;
                row_d   = '0;
                oidx_d  = '0;
            end
            S_STREAM: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            // Cover the read latency plus the capture cycle so the last
            // window is reported before done.
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = S_DONE;
                else                       drain_d = drain_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Index advances after each reported window; LOAD never overlaps a
        // pending valid because the previous frame has fully drained.
        if (valid) oidx_d = oidx_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
            oidx_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            oidx_q  <= oidx_d;
        end
    end

    // Columns left of KERNEL_SIZE-1 would pull pixels from the previous row.
    assign tag = (state_q == S_STREAM) && (row_q >= WIN_START) && (col_q >= WIN_START);

    valid_delay_line #(.DEPTH(RD_LATENCY + 1)) u_vdl (
        .clk   (clk),
        .rst   (reset),
        .tag_i (tag),
        .tag_o (valid)
    );

    assign weight_write = (state_q == S_LOAD);
    assign pixel_rd_en  = (state_q == S_STREAM);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign pixel_addr   = addr_q;
    assign out_valid    = valid;
    assign out_addr     = oidx_q;

`ifdef CONV_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                perf_q <= '0;
        else if (state_q == S_IDLE && start)      perf_q <= '0;
        else if (state_q != S_IDLE && perf_q != '1) perf_q <= perf_q + 1'b1;
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv_controller.sv
module tb_conv_controller;
    import conv_pkg::*;

    localparam int K   = 5;
    localparam int IMG = 28;
    localparam int OE  = IMG - K + 1;
    localparam int FR  = IMG * IMG;
    localparam int NOUT = OE * OE;
    localparam int WIN = (K - 1) * IMG + K;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start1 = 1'b0, start3 = 1'b0;

    logic       ww1, rd1, ov1, busy1, done1;
    logic [9:0] pa1, oa1;
    logic       ww3, rd3, ov3, busy3, done3;
    logic [9:0] pa3, oa3;
`ifdef CONV_PERF_CNT_EN
    logic [31:0] perf1, perf3;
`endif

    always #5 clk = ~clk;

    conv_controller dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .weight_write(ww1), .pixel_rd_en(rd1), .pixel_addr(pa1),
        .out_valid(ov1), .out_addr(oa1), .busy(busy1),
`ifdef CONV_PERF_CNT_EN
        .perf_cycles(perf1),
`endif
        .done(done1)
    );

    conv_controller #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .weight_write(ww3), .pixel_rd_en(rd3), .pixel_addr(pa3),
        .out_valid(ov3), .out_addr(oa3), .busy(busy3),
`ifdef CONV_PERF_CNT_EN
        .perf_cycles(perf3),
`endif
        .done(done3)
    );

    // ---------------- datapath model behind dut1 ----------------
    int mem [FR];
    int wgt [K*K];
    int bias;
    int dp_w [K*K];
    int dp_b;
    int rdata;
    int sr [WIN];
    int add_result;

    always @(posedge clk) if (ww1) begin dp_w <= wgt; dp_b <= bias; end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= 0;
            for (int k = 0; k < WIN; k++) sr[k] <= 0;
        end else begin
            if (rd1) rdata <= mem[pa1];
            sr[0] <= rdata;
            for (int k = 1; k < WIN; k++) sr[k] <= sr[k-1];
        end
    end

    // sr[j] holds the pixel j positions before the newest one
    always_comb begin
        add_result = dp_b;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                add_result += dp_w[ky*K+kx] * sr[(K-1-ky)*IMG + (K-1-kx)];
    end

    function automatic int golden(input int o);
        int orow, ocol, s;
        orow = o / OE;
        ocol = o % OE;
        s = bias;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                s += wgt[ky*K+kx] * mem[(orow+ky)*IMG + ocol + kx];
        return s;
    endfunction

    // ---------------- scoreboard / checking ----------------
    typedef struct { int oa; int val; } exp_t;
    exp_t sbq[$];

    typedef struct {
        int   cyc;
        logic ww, rd;
        int   pa;
        logic ov;
        int   oa;
        logic busy, done;
    } vec_t;
    vec_t tbl [14];

    int checks = 0, errors = 0;
    int cur_t = 0;
    int pulses;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %0d expected %0d", name, cur_t, act, exp);
        end
    endtask

    task automatic check_cycle1(input int t);
        int  i;
        logic exp_ov;
        exp_t e;
        cur_t = t;
        i = t - 4;
        exp_ov = (i >= 0) && (i < FR) && ((i / IMG) >= K-1) && ((i % IMG) >= K-1);
        chk("ww1", ww1, t == 1);
        chk("busy1", busy1, t >= 1 && t <= 788);
        chk("done1", done1, t == 788);
        chk("rd_en1", rd1, t >= 2 && t <= 785);
        if (t >= 2 && t <= 785) chk("pixel_addr1", pa1, t - 2);
        chk("out_valid1", ov1, exp_ov);
        if (ov1 === 1'b1) begin
            pulses++;
            if (sbq.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("out_addr1", oa1, e.oa);
                chk("add_result", add_result, e.val);
            end
        end
        foreach (tbl[n]) if (tbl[n].cyc == t) begin
            chk("tbl_ww", ww1, tbl[n].ww);
            chk("tbl_rd", rd1, tbl[n].rd);
            if (tbl[n].pa >= 0) chk("tbl_pa", pa1, tbl[n].pa);
            chk("tbl_ov", ov1, tbl[n].ov);
            if (tbl[n].oa >= 0) chk("tbl_oa", oa1, tbl[n].oa);
            chk("tbl_busy", busy1, tbl[n].busy);
            chk("tbl_done", done1, tbl[n].done);
        end
`ifdef CONV_PERF_CNT_EN
        if (t == 789) chk("perf1", perf1, 788);
`endif
    endtask

    // One full frame on dut1; extra=1 adds ignored starts in STREAM and DONE
    // and a start in the following IDLE cycle.
    task automatic run_frame1(input bit extra);
        exp_t e;
        sbq.delete();
        for (int o = 0; o < NOUT; o++) begin
            e.oa = o; e.val = golden(o);
            sbq.push_back(e);
        end
        pulses = 0;
        @(posedge clk); #1;
        for (int t = 0; t <= 789; t++) begin
            check_cycle1(t);
            start1 = (t == 0) || (extra && (t == 400 || t == 788 || t == 789));
            @(posedge clk); #1;
        end
        start1 = 0;
        cur_t = 790;
        chk("pulse_count1", pulses, NOUT);
        chk("sb_left", sbq.size(), 0);
        if (extra) begin
            chk("restart_ww", ww1, 1);
            chk("restart_busy", busy1, 1);
        end
    endtask

    initial begin
        int n, cnt, i;
        logic exp_ov;

        foreach (mem[k]) mem[k] = int'($urandom_range(0, 255));
        foreach (wgt[k]) wgt[k] = int'($urandom_range(0, 15)) - 8;
        bias = 37;

        tbl[0]  = '{0,   0, 0, -1,  0, -1,  0, 0};
        tbl[1]  = '{1,   1, 0, -1,  0, -1,  1, 0};
        tbl[2]  = '{2,   0, 1, 0,   0, 0,   1, 0};
        tbl[3]  = '{3,   0, 1, 1,   0, 0,   1, 0};
        tbl[4]  = '{119, 0, 1, 117, 0, 0,   1, 0};
        tbl[5]  = '{120, 0, 1, 118, 1, 0,   1, 0};
        tbl[6]  = '{121, 0, 1, 119, 1, 1,   1, 0};
        tbl[7]  = '{144, 0, 1, 142, 0, 24,  1, 0};
        tbl[8]  = '{148, 0, 1, 146, 1, 24,  1, 0};
        tbl[9]  = '{785, 0, 1, 783, 1, 573, 1, 0};
        tbl[10] = '{786, 0, 0, -1,  1, 574, 1, 0};
        tbl[11] = '{787, 0, 0, -1,  1, 575, 1, 0};
        tbl[12] = '{788, 0, 0, -1,  0, 576, 1, 1};
        tbl[13] = '{789, 0, 0, -1,  0, 576, 0, 0};

        // reset state
        reset = 1;
        #12;
        cur_t = -1;
        chk("rst_ww", ww1, 0);   chk("rst_rd", rd1, 0);    chk("rst_pa", pa1, 0);
        chk("rst_ov", ov1, 0);   chk("rst_oa", oa1, 0);    chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_busy3", busy3, 0); chk("rst_ov3", ov3, 0);
`ifdef CONV_PERF_CNT_EN
        chk("rst_perf", perf1, 0);
`endif
        @(posedge clk); #1; reset = 0;

        // full frame, golden compare
        run_frame1(0);

        // asynchronous reset mid-STREAM, then a clean frame
        @(posedge clk); #1; start1 = 1;
        @(posedge clk); #1; start1 = 0;
        n = 0;
        while (!(rd1 === 1'b1 && pa1 == 10'd300)) begin
            @(posedge clk); #1;
            n++;
            if (n > 2000) begin chk("wait_addr300", 0, 1); break; end
        end
        #2 reset = 1;
        #1;
        cur_t = -2;
        chk("arst_ww", ww1, 0);  chk("arst_rd", rd1, 0);   chk("arst_pa", pa1, 0);
        chk("arst_ov", ov1, 0);  chk("arst_oa", oa1, 0);   chk("arst_busy", busy1, 0);
        chk("arst_done", done1, 0);
        @(posedge clk); #1; reset = 0;
        run_frame1(0);

        // ignored starts during STREAM and DONE, accepted in next IDLE
        run_frame1(1);
        #1 reset = 1;
        @(posedge clk); #1; reset = 0;

        // RD_LATENCY=3 instance
        @(posedge clk); #1;
        cnt = 0;
        for (int t = 0; t <= 795; t++) begin
            cur_t = t;
            i = t - 6;
            exp_ov = (i >= 0) && (i < FR) && ((i / IMG) >= K-1) && ((i % IMG) >= K-1);
            chk("ww3", ww3, t == 1);
            chk("busy3", busy3, t >= 1 && t <= 790);
            chk("done3", done3, t == 790);
            chk("rd_en3", rd3, t >= 2 && t <= 785);
            if (t >= 2 && t <= 785) chk("pixel_addr3", pa3, t - 2);
            chk("out_valid3", ov3, exp_ov);
            if (t == 122) chk("first_ov3", {ov3, oa3}, {1'b1, 10'd0});
            if (ov3 === 1'b1) begin
                chk("out_addr3", oa3, cnt);
                cnt++;
            end
`ifdef CONV_PERF_CNT_EN
            if (t >= 1 && t <= 791) chk("perf3", perf3, t - 1);
            else if (t > 791)       chk("perf3_hold", perf3, 790);
`endif
            start3 = (t == 0);
            @(posedge clk); #1;
        end
        start3 = 0;
        chk("pulse_count3", cnt, NOUT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
